// File: rtl/ag_o_addr_gen.sv
// In-block address generator for the systolic-array output RAM.
// Walks a P-strided, column-interleaved sequence over M feature slots.
module ag_o_addr_gen #(
  parameter int unsigned FEATURE_BITS = 4,
  parameter int unsigned P            = 4,
  parameter int unsigned M            = 9,
  parameter int unsigned GAMMA        = 3,
  parameter int unsigned R            = 1
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [FEATURE_BITS-1:0] address
);

  // One extra bit so the stride and column sums never wrap before comparison.
  localparam int unsigned SUM_W = FEATURE_BITS + 1;

  // Reject configurations the sequence cannot represent; GAMMA belongs to the wrapper.
  if ((M > (2 ** FEATURE_BITS)) || (M == 0) || (R < 1) || (R >= P) || (GAMMA == 0)) begin : g_bad_params
    $error("ag_o_addr_gen: illegal parameter combination");
  end

  logic [FEATURE_BITS-1:0] r_addr;
  logic [FEATURE_BITS-1:0] r_col;
  logic [SUM_W-1:0]        w_next;
  logic [SUM_W-1:0]        w_ncol;
  logic                    w_in_col;
  logic                    w_col_ok;

  assign w_next   = SUM_W'(r_addr) + SUM_W'(P);
  assign w_ncol   = SUM_W'(r_col) + SUM_W'(R);
  assign w_in_col = (w_next <= SUM_W'(M - 1));
  assign w_col_ok = (w_ncol < SUM_W'(P)) && (w_ncol <= SUM_W'(M - 1));

  // Stride down the column, then hop to the next column, then wrap the period.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_col  <= '0;
    end else if (start) begin
      if (w_in_col) begin
        r_addr <= FEATURE_BITS'(w_next);
      end else if (w_col_ok) begin
        r_col  <= FEATURE_BITS'(w_ncol);
        r_addr <= FEATURE_BITS'(w_ncol);
      end else begin
        r_col  <= '0;
        r_addr <= '0;
      end
    end
  end

  assign address = r_addr;

endmodule

// File: tb/tb_ag_o_addr_gen.sv
// Scoreboard bench: three configurations driven by shared random start/reset,
// each checked against the period sequence enumerated from column/stride rules.
module tb_ag_o_addr_gen;

  typedef int q_t[$];

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] addr0, addr1, addr2;

  int checks = 0;
  int errors = 0;

  q_t seq0, seq1, seq2;
  q_t exp0, exp1, exp2;
  int idx0 = 0, idx1 = 0, idx2 = 0;

  always #5 sys_clk = ~sys_clk;

  ag_o_addr_gen #(.FEATURE_BITS(4), .P(4), .M(9), .GAMMA(3), .R(1)) u_d0 (
    .sys_clk(sys_clk), .reset(reset), .start(start), .address(addr0));
  ag_o_addr_gen #(.FEATURE_BITS(4), .P(4), .M(9), .GAMMA(3), .R(2)) u_d1 (
    .sys_clk(sys_clk), .reset(reset), .start(start), .address(addr1));
  ag_o_addr_gen #(.FEATURE_BITS(4), .P(4), .M(3), .GAMMA(3), .R(1)) u_d2 (
    .sys_clk(sys_clk), .reset(reset), .start(start), .address(addr2));

  // One full period: every column c = 0, R, 2R.. below P and M, strided by P below M.
  function automatic q_t build(int p, int m, int r);
    q_t s;
    for (int c = 0; c < p && c < m; c += r)
      for (int a = c; a < m; a += p)
        s.push_back(a);
    return s;
  endfunction

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  // Reference model: advance position in the period on each start-qualified edge.
  always @(posedge sys_clk) begin
    if (!reset) begin
      if (start) begin
        idx0 = (idx0 + 1) % seq0.size();
        idx1 = (idx1 + 1) % seq1.size();
        idx2 = (idx2 + 1) % seq2.size();
      end
      exp0.push_back(seq0[idx0]);
      exp1.push_back(seq1[idx1]);
      exp2.push_back(seq2[idx2]);
    end
  end

  // Monitor: compare the registered address mid-cycle against the scoreboard.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (exp0.size() > 0) check("d0_addr", int'(addr0), exp0.pop_front());
      if (exp1.size() > 0) check("d1_addr", int'(addr1), exp1.pop_front());
      if (exp2.size() > 0) check("d2_addr", int'(addr2), exp2.pop_front());
    end
  end

  // Asserts reset between edges; the address must clear without a clock.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    check("rst_async_d0", int'(addr0), 0);
    check("rst_async_d1", int'(addr1), 0);
    check("rst_async_d2", int'(addr2), 0);
    exp0.delete(); exp1.delete(); exp2.delete();
    idx0 = 0; idx1 = 0; idx2 = 0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    seq0 = build(4, 9, 1);
    seq1 = build(4, 9, 2);
    seq2 = build(4, 3, 1);
    reset = 1'b1;
    start = 1'b0;
    #1;
    check("rst_d0", int'(addr0), 0);
    check("rst_d1", int'(addr1), 0);
    check("rst_d2", int'(addr2), 0);

    // Held in reset with start low for five clocks.
    repeat (5) begin
      @(negedge sys_clk);
      check("rst_hold_d0", int'(addr0), 0);
      check("rst_hold_d2", int'(addr2), 0);
    end
    reset = 1'b0;

    // Idle a few clocks, then run continuously past two full periods.
    repeat (3) @(negedge sys_clk);
    start = 1'b1;
    repeat (20) @(negedge sys_clk);

    @(posedge sys_clk); #2;
    async_reset();

    // Start toggling pattern: holds while start is low.
    foreach (seq0[i]) begin
      if (i < 5) begin
        start = (i == 2 || i == 3) ? 1'b0 : 1'b1;
        @(negedge sys_clk);
      end
    end

    // Reset aborts mid-sequence when d0 sits at address 5.
    start = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge sys_clk); #2;
      if (addr0 == 4'd5) begin
        found = 1'b1;
        async_reset();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_addr5: address 5 never seen within 40 cycles, expected it");
    end
    repeat (12) @(negedge sys_clk);

    // Randomized start with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      @(negedge sys_clk);
      start = ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 99) < 3) begin
        @(posedge sys_clk); #($urandom_range(1, 3));
        async_reset();
      end
    end

    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ag_o_addr_gen.md
Name: ag_o_addr_gen

Overview:
- Base address generator for the systolic-array output (sys_out) dual-port RAM.
- Produces a FEATURE_BITS-wide read/write address that walks a P-strided, column-interleaved sequence over M feature slots.
- An outer wrapper adds a per-period block offset (multiples of M) and counts GAMMA periods.
- This block only generates the in-block address; it has no done output.

Parameters:
- FEATURE_BITS, 4: address width; M must not exceed 2^FEATURE_BITS.
- P, 3'b100 (4): systolic array dimension; address stride within a column.
- M, 4'b1001 (9): number of feature slots per period; addresses lie in 0..M-1.
- GAMMA, 4'b0011 (3): number of periods counted by the wrapper; carried for interface compatibility only, with no effect inside this block.
- R, 4'b0001 (1): column step applied when a column is exhausted; must satisfy 1 <= R < P.

Ports:
- sys_clk  input  1  systolic array clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  advance enable; while high, the address steps once per clock.
- address  output  FEATURE_BITS  current in-block address, registered.

Behaviour:
- State consists of two registers:
  - addr: FEATURE_BITS bits, drives address directly.
  - col: current column base, FEATURE_BITS bits.
- Reset (asynchronous, active-high): addr=0, col=0. Reset mid-sequence aborts immediately; the sequence restarts from 0 after reset deasserts.
- start=0 at a rising edge: addr and col hold.
- start=1 at a rising edge: compute next = addr + P at FEATURE_BITS+1 bits, so there is no overflow wrap.
  - If next <= M-1: addr <= next; col unchanged.
  - Else (column exhausted): ncol = col + R at FEATURE_BITS+1 bits.
    - If ncol < P and ncol <= M-1: col <= ncol, addr <= ncol.
    - Otherwise (period complete): col <= 0, addr <= 0.
- Latency:
  - address is valid as the current value; the first address (0) is present before the first start edge.
  - Each start-qualified edge presents the next address one cycle later.
- With R=1, one period visits every value 0..M-1 exactly once, in exactly M cycles. This keeps the period aligned with the wrapper's modulo-M counter.
- With R>1, the period covers only columns 0, R, 2R, ... below P, and is shorter than M.
- Degenerate case P >= M: every column holds a single address. The sequence is 0, R, 2R, ... until the next column value reaches P or M, then returns to 0.
- No combinational path from start to address; the output is purely registered.
- Arithmetic is unsigned; comparisons use the widened sums.

Test Plan:
- Reset asserted, start=0 -> address=0; held for 5 clocks with start=0 -> address stays 0.
- Defaults (P=4, M=9, R=1), start=1 for 20 clocks -> address sequence 0,4,8,1,5,2,6,3,7,0,4,8,1,5,2,6,3,7,0,4.
- Defaults, start toggled 1,1,0,0,1 after reset -> address 0,4,8,8,8,1 (holds while start=0).
- Defaults, reset asserted asynchronously when address=5 (between clock edges) -> address goes to 0 immediately; after release with start=1 -> 0,4,8,1...
- R=2 (P=4, M=9), start=1 -> 0,4,8,2,6,0,4,8,2,6 (period 5).
- P=4, M=3, R=1, FEATURE_BITS=4, start=1 -> 0,1,2,0,1,2 (single-entry columns, no overflow).
